sysbus_arbiter: RTL and testbench

SYSBUS_ARBITER -- requirements
Module: sysbus_arbiter

---
 rtl/sysbus_arb_pkg.sv | 22 ++
 rtl/rr_picker.sv | 19 +
 rtl/sysbus_arbiter.sv | 136 +++++++++++++
 tb/tb_sysbus_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysbus_arb_pkg.sv
// Shared types and constants for the two-port system bus arbiter.
package sysbus_arb_pkg;

    localparam int NREQ = 2;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam logic [3:0] BEATS_MAX = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_XFER  = 2'd3
    } state_e;

    function automatic logic [3:0] beats_sat_inc(input logic [3:0] v);
        return (v == BEATS_MAX) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Two-way round-robin choice: on a tie the port that was not served last wins.
module rr_picker
    import sysbus_arb_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic            last_i,
    output logic            grant_o
);

    always_comb begin
        grant_o = PORT_FETCH;
        if (req_i[PORT_FETCH] && req_i[PORT_DATA]) begin
            grant_o = ~last_i;
        end else if (req_i[PORT_DATA]) begin
            grant_o = PORT_DATA;
        end
    end

endmodule

// File: rtl/sysbus_arbiter.sv
// Single-outstanding arbiter joining the fetch and data ports onto one system bus,
// with response steering back to the owning port.
module sysbus_arbiter
    import sysbus_arb_pkg::*;
#(
    parameter int TAG_W = 13
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             rq_reqcyc,
    input  logic [NREQ-1:0][63:0]       rq_req,
    input  logic [NREQ-1:0][TAG_W-1:0]  rq_reqtag,
    output logic [NREQ-1:0]             rq_reqack,
    output logic [NREQ-1:0]             rq_respcyc,
    input  logic [NREQ-1:0]             rq_respack,
    output logic [63:0]                 rq_resp,
    output logic [TAG_W-1:0]            rq_resptag,
    output logic                        bus_reqcyc,
    output logic [63:0]                 bus_req,
    output logic [TAG_W-1:0]            bus_reqtag,
    input  logic                        bus_reqack,
    input  logic                        bus_respcyc,
    output logic                        bus_respack,
    input  logic [63:0]                 bus_resp,
    input  logic [TAG_W-1:0]            bus_resptag,
    output logic                        owner,
    output logic                        busy,
    output logic [3:0]                  beats,
    output logic                        err_unexpected
);

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic [3:0]       beats_q, beats_d;
    logic [63:0]      req_q, req_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             grant;

    rr_picker u_pick (
        .req_i   (rq_reqcyc),
        .last_i  (last_q),
        .grant_o (grant)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= PORT_FETCH;
            last_q  <= PORT_DATA;
            beats_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beats_q <= beats_d;
            err_q   <= err_d;
        end
    end

    // Request payload is only visible through ISSUE-gated outputs, so it needs no reset.
    always_ff @(posedge clk) begin
        req_q <= req_d;
        tag_q <= tag_d;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        beats_d     = beats_q;
        err_d       = err_q;
        req_d       = req_q;
        tag_d       = tag_q;
        rq_reqack   = '0;
        rq_respcyc  = '0;
        rq_resp     = '0;
        rq_resptag  = '0;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus_respcyc) begin
                    err_d = 1'b1;
                end
                if (|rq_reqcyc) begin
                    owner_d = grant;
                    req_d   = rq_req[grant];
                    tag_d   = rq_reqtag[grant];
                    beats_d = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus_respcyc) begin
                    err_d = 1'b1;
                end
                bus_reqcyc         = 1'b1;
                bus_req            = req_q;
                bus_reqtag         = tag_q;
                rq_reqack[owner_q] = bus_reqack;
                if (bus_reqack) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT, ST_XFER: begin
                // The first beat can already be accepted in WAIT, so it is counted there too.
                rq_respcyc[owner_q] = bus_respcyc;
                bus_respack         = rq_respack[owner_q];
                rq_resp             = bus_resp;
                rq_resptag          = bus_resptag;
                if (bus_respcyc && rq_respack[owner_q]) begin
                    beats_d = beats_sat_inc(beats_q);
                end
                if (bus_respcyc) begin
                    state_d = ST_XFER;
                end else if (state_q == ST_XFER) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign owner          = owner_q;
    assign busy           = (state_q != ST_IDLE);
    assign beats          = beats_q;
    assign err_unexpected = err_q;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Bench for sysbus_arbiter: vector table, directed corner sequences and a randomized
// run against a transaction-level reference model.
module tb_sysbus_arbiter;

    localparam int TAG_W = 13;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [1:0]               rq_reqcyc;
    logic [1:0][63:0]         rq_req;
    logic [1:0][TAG_W-1:0]    rq_reqtag;
    logic [1:0]               rq_reqack;
    logic [1:0]               rq_respcyc;
    logic [1:0]               rq_respack;
    logic [63:0]              rq_resp;
    logic [TAG_W-1:0]         rq_resptag;
    logic                     bus_reqcyc;
    logic [63:0]              bus_req;
    logic [TAG_W-1:0]         bus_reqtag;
    logic                     bus_reqack;
    logic                     bus_respcyc;
    logic                     bus_respack;
    logic [63:0]              bus_resp;
    logic [TAG_W-1:0]         bus_resptag;
    logic                     owner;
    logic                     busy;
    logic [3:0]               beats;
    logic                     err_unexpected;

    int errors = 0;
    int checks = 0;

    sysbus_arbiter #(.TAG_W(TAG_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .rq_reqcyc      (rq_reqcyc),
        .rq_req         (rq_req),
        .rq_reqtag      (rq_reqtag),
        .rq_reqack      (rq_reqack),
        .rq_respcyc     (rq_respcyc),
        .rq_respack     (rq_respack),
        .rq_resp        (rq_resp),
        .rq_resptag     (rq_resptag),
        .bus_reqcyc     (bus_reqcyc),
        .bus_req        (bus_req),
        .bus_reqtag     (bus_reqtag),
        .bus_reqack     (bus_reqack),
        .bus_respcyc    (bus_respcyc),
        .bus_respack    (bus_respack),
        .bus_resp       (bus_resp),
        .bus_resptag    (bus_resptag),
        .owner          (owner),
        .busy           (busy),
        .beats          (beats),
        .err_unexpected (err_unexpected)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    typedef struct packed {
        logic [1:0] rqc;
        logic       back;
        logic       bresp;
        logic       e_brc;
        logic [1:0] e_rack;
        logic [1:0] e_rsp;
        logic       e_bra;
        logic       e_busy;
        logic [3:0] e_beats;
    } vec_t;

    vec_t tbl [14];

    // Reference model and random agents
    logic             m_busy, m_acked, m_inburst, m_owner, m_last, m_err;
    logic [3:0]       m_beats;
    logic [63:0]      m_addr;
    logic [TAG_W-1:0] m_tag;
    logic             e_brc, e_bra;
    logic [1:0]       e_rack, e_rsp;
    logic [1:0]       pend;
    logic             s_on, adv;
    int               s_delay, s_left;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl"}, 64'({rq_reqack, rq_respcyc, rq_resptag, bus_reqcyc, bus_reqtag,
                                 bus_respack, owner, busy, beats, err_unexpected}), 64'h0);
        chk({name, "_resp"}, rq_resp, 64'h0);
        chk({name, "_breq"}, bus_req, 64'h0);
    endtask

    task automatic idle_in();
        rq_reqcyc   = '0;
        rq_req      = '0;
        rq_reqtag   = '0;
        rq_respack  = 2'b11;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        bus_resptag = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_in();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        idle_in();
        // Reset state with every input active
        #2 reset = 1'b0;
        rq_reqcyc   = 2'b11;
        rq_req[0]   = 64'h1111;
        rq_req[1]   = 64'h2222;
        bus_respcyc = 1'b1;
        bus_reqack  = 1'b1;
        bus_resp    = 64'hDEAD_BEEF;
        bus_resptag = 13'h155;
        #1;
        chk_zero("rst0");
        tick(); #2;
        chk_zero("rst1");
        tick(); #2;
        chk_zero("rst2");
        idle_in();
        reset = 1'b1;
        tick();

        // Single fetch, 8-beat burst, as a vector table
        tbl[0]  = '{2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 4'd0};
        tbl[2]  = '{2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 4'd0};
        tbl[3]  = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 4'd0};
        for (int i = 0; i < 8; i++)
            tbl[4+i] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 4'(i)};
        tbl[12] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 4'd8};
        tbl[13] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 4'd8};
        rq_req[0]    = 64'h1000;
        rq_reqtag[0] = 13'h0AB;
        for (int i = 0; i < 14; i++) begin
            rq_reqcyc   = tbl[i].rqc;
            bus_reqack  = tbl[i].back;
            bus_respcyc = tbl[i].bresp;
            bus_resp    = 64'hB000 + 64'(i);
            #2;
            chk("tbl_brc",   64'(bus_reqcyc),  64'(tbl[i].e_brc));
            chk("tbl_rack",  64'(rq_reqack),   64'(tbl[i].e_rack));
            chk("tbl_rsp",   64'(rq_respcyc),  64'(tbl[i].e_rsp));
            chk("tbl_bra",   64'(bus_respack), 64'(tbl[i].e_bra));
            chk("tbl_busy",  64'(busy),        64'(tbl[i].e_busy));
            chk("tbl_beats", 64'(beats),       64'(tbl[i].e_beats));
            chk("tbl_owner", 64'(owner),       64'h0);
            chk("tbl_breq",  bus_req,          tbl[i].e_brc ? 64'h1000 : 64'h0);
            chk("tbl_btag",  64'(bus_reqtag),  tbl[i].e_brc ? 64'h0AB : 64'h0);
            if (tbl[i].e_rsp != 2'b00)
                chk("tbl_resp", rq_resp, 64'hB000 + 64'(i));
            tick();
        end

        // Simultaneous requests from reset, then alternating ties
        do_reset();
        rq_reqcyc = 2'b11; rq_req[0] = 64'hA0; rq_req[1] = 64'hA1;
        #2; chk("tie_idle", 64'(busy), 64'h0); tick();
        bus_reqack = 1'b1;
        #2;
        chk("tie_own0", 64'(owner), 64'h0);
        chk("tie_breq0", bus_req, 64'hA0);
        chk("tie_rack0", 64'(rq_reqack), 64'h1);
        tick();
        bus_reqack = 1'b0; rq_req[0] = 64'hA2; bus_respcyc = 1'b1;
        #2; chk("tie_rsp0", 64'(rq_respcyc), 64'h1); tick();
        bus_respcyc = 1'b0;
        #2; chk("tie_xfer", 64'(busy), 64'h1); tick();
        #2;
        chk("tie_dead_busy", 64'(busy), 64'h0);
        chk("tie_dead_brc", 64'(bus_reqcyc), 64'h0);
        tick();
        bus_reqack = 1'b1;
        #2;
        chk("tie_own1", 64'(owner), 64'h1);
        chk("tie_breq1", bus_req, 64'hA1);
        chk("tie_rack1", 64'(rq_reqack), 64'h2);
        tick();
        bus_reqack = 1'b0; rq_reqcyc = 2'b01; bus_respcyc = 1'b1;
        #2; chk("tie_rsp1", 64'(rq_respcyc), 64'h2); tick();
        bus_respcyc = 1'b0;
        tick();
        rq_reqcyc = 2'b11; rq_req[1] = 64'hA3;
        #2; chk("tie2_idle", 64'(busy), 64'h0); tick();
        #2;
        chk("tie2_own", 64'(owner), 64'h0);
        chk("tie2_breq", bus_req, 64'hA2);

        // Response backpressure from port 1
        do_reset();
        rq_reqcyc = 2'b10; rq_req[1] = 64'h3000;
        #2; tick();
        bus_reqack = 1'b1;
        #2; chk("bp_rack", 64'(rq_reqack), 64'h2); tick();
        bus_reqack = 1'b0; rq_reqcyc = 2'b00; bus_respcyc = 1'b1;
        #2; chk("bp_beats0", 64'(beats), 64'h0); tick();
        #2;
        chk("bp_beats1", 64'(beats), 64'h1);
        chk("bp_bra1", 64'(bus_respack), 64'h1);
        tick();
        rq_respack = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("bp_bra_hold", 64'(bus_respack), 64'h0);
            chk("bp_beats_hold", 64'(beats), 64'h2);
            chk("bp_rsp_hold", 64'(rq_respcyc), 64'h2);
            tick();
        end
        rq_respack = 2'b11;
        #2;
        chk("bp_bra_rel", 64'(bus_respack), 64'h1);
        chk("bp_beats_rel", 64'(beats), 64'h2);
        tick();
        bus_respcyc = 1'b0;
        #2; chk("bp_beats_end", 64'(beats), 64'h3); tick();
        #2; chk("bp_idle", 64'(busy), 64'h0);

        // Stray response while idle
        tick();
        bus_respcyc = 1'b1;
        #2;
        chk("stray_bra", 64'(bus_respack), 64'h0);
        chk("stray_rsp", 64'(rq_respcyc), 64'h0);
        chk("stray_err_pre", 64'(err_unexpected), 64'h0);
        tick();
        bus_respcyc = 1'b0;
        #2; chk("stray_err", 64'(err_unexpected), 64'h1); tick();
        tick();
        #2; chk("stray_err_sticky", 64'(err_unexpected), 64'h1);

        // Reset in the middle of a burst
        do_reset();
        #2; chk("mid_err_clr", 64'(err_unexpected), 64'h0); tick();
        rq_reqcyc = 2'b01; rq_req[0] = 64'h5000;
        #2; tick();
        bus_reqack = 1'b1;
        #2; tick();
        bus_reqack = 1'b0; rq_reqcyc = 2'b00; bus_respcyc = 1'b1; bus_resp = 64'hCAFE;
        tick(); tick(); tick();
        #2; chk("mid_beats3", 64'(beats), 64'h3);
        reset = 1'b0;
        #1; chk_zero("mid_rst_now");
        tick(); #2; chk_zero("mid_rst_hold");
        reset = 1'b1;
        idle_in();
        tick();
        rq_reqcyc = 2'b10; rq_req[1] = 64'h4000;
        #2; chk("mid_new_idle", 64'(busy), 64'h0); tick();
        #2;
        chk("mid_new_brc", 64'(bus_reqcyc), 64'h1);
        chk("mid_new_breq", bus_req, 64'h4000);
        chk("mid_new_own", 64'(owner), 64'h1);
        chk("mid_new_beats", 64'(beats), 64'h0);

        // Request payload changing after grant
        do_reset();
        rq_reqcyc = 2'b01; rq_req[0] = 64'h1000;
        #2; tick();
        rq_req[0] = 64'h2000;
        #2; chk("chg_breq_a", bus_req, 64'h1000); tick();
        bus_reqack = 1'b1;
        #2;
        chk("chg_breq_b", bus_req, 64'h1000);
        chk("chg_rack", 64'(rq_reqack), 64'h1);
        tick();

        // Randomized traffic against the reference model
        do_reset();
        m_busy = 1'b0; m_acked = 1'b0; m_inburst = 1'b0; m_owner = 1'b0; m_last = 1'b1;
        m_err = 1'b0; m_beats = 4'd0; m_addr = '0; m_tag = '0;
        pend = 2'b00; s_on = 1'b0; adv = 1'b0; s_delay = 0; s_left = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p]      = 1'b1;
                    rq_req[p]    = {$urandom, $urandom};
                    rq_reqtag[p] = TAG_W'($urandom);
                end else if (pend[p] && $urandom_range(0, 7) == 0) begin
                    rq_req[p] = {$urandom, $urandom};
                end
            end
            rq_reqcyc  = pend;
            rq_respack = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            bus_reqack = ($urandom_range(0, 1) == 0);
            if (adv) begin
                bus_resp    = {$urandom, $urandom};
                bus_resptag = TAG_W'($urandom);
                adv         = 1'b0;
            end
            bus_respcyc = (s_on && s_delay == 0 && s_left > 0) ||
                          (!m_acked && $urandom_range(0, 299) == 0);
            #2;
            e_brc  = m_busy && !m_acked;
            e_rack = (e_brc && bus_reqack) ? (2'b01 << m_owner) : 2'b00;
            e_rsp  = (m_acked && bus_respcyc) ? (2'b01 << m_owner) : 2'b00;
            e_bra  = m_acked ? rq_respack[m_owner] : 1'b0;
            chk("rnd_ctl", 64'({bus_reqcyc, rq_reqack, rq_respcyc, bus_respack, busy, owner, beats, err_unexpected}),
                           64'({e_brc, e_rack, e_rsp, e_bra, m_busy, m_owner, m_beats, m_err}));
            chk("rnd_breq", bus_req, e_brc ? m_addr : 64'h0);
            chk("rnd_btag", 64'(bus_reqtag), e_brc ? 64'(m_tag) : 64'h0);
            chk("rnd_resp", rq_resp, m_acked ? bus_resp : 64'h0);
            chk("rnd_rtag", 64'(rq_resptag), m_acked ? 64'(bus_resptag) : 64'h0);

            if (!m_busy) begin
                if (bus_respcyc) m_err = 1'b1;
                if (pend != 2'b00) begin
                    m_owner   = (pend == 2'b11) ? ~m_last : pend[1];
                    m_addr    = rq_req[m_owner];
                    m_tag     = rq_reqtag[m_owner];
                    m_busy    = 1'b1;
                    m_acked   = 1'b0;
                    m_inburst = 1'b0;
                    m_beats   = 4'd0;
                end
            end else if (!m_acked) begin
                if (bus_respcyc) m_err = 1'b1;
                if (bus_reqack) m_acked = 1'b1;
            end else if (bus_respcyc) begin
                m_inburst = 1'b1;
                if (rq_respack[m_owner]) m_beats = (m_beats == 4'd15) ? 4'd15 : m_beats + 4'd1;
            end else if (m_inburst) begin
                m_busy  = 1'b0;
                m_acked = 1'b0;
                m_last  = m_owner;
            end

            for (int p = 0; p < 2; p++)
                if (rq_reqack[p]) pend[p] = 1'b0;
            if (bus_reqcyc && bus_reqack) begin
                s_on    = 1'b1;
                s_delay = $urandom_range(0, 3);
                s_left  = $urandom_range(1, 20);
                adv     = 1'b1;
            end else if (s_on) begin
                if (bus_respcyc && bus_respack) begin
                    s_left--;
                    adv = 1'b1;
                end else if (s_delay > 0) begin
                    s_delay--;
                end
                if (s_left == 0) s_on = 1'b0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
